// File: rtl/seq_reorder_buffer_pkg.sv
// Shared type codes, field layout helpers and default packet struct for the PE receive path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package snc_pkg;

   // Packet type codes carried in the MSB field of every packet.
   localparam logic [1:0] DATA          = 2'b00;
   localparam logic [1:0] CONF_INPUTNUM = 2'b01;

   // Default field widths, used by the packet struct below.
   localparam int DEF_NETWORK_SIZE  = 256;
   localparam int DEF_PAYLOAD_WIDTH = 22;
   localparam int DEF_SEQ_WIDTH     = 4;
   localparam int DEF_TYPE_WIDTH    = 2;
   localparam int DEF_NODE_WIDTH    = $clog2(DEF_NETWORK_SIZE);

   // Width of a node address (source or dest) for a given network size.
   function automatic int node_width(input int network_size);
      return $clog2(network_size);
   endfunction

   // Total packet width: {type, dest, source, seq, payload}.
   function automatic int packet_size(input int network_size, input int payload_width,
                                      input int seq_width, input int type_width);
      return type_width + 2 * node_width(network_size) + seq_width + payload_width;
   endfunction

   // The payload sits at bit 0, so the sequence field starts right above it.
   function automatic int seq_lsb(input int payload_width);
      return payload_width;
   endfunction

   // Source field LSB.
   function automatic int source_lsb(input int payload_width, input int seq_width);
      return payload_width + seq_width;
   endfunction

   // Dest field LSB.
   function automatic int dest_lsb(input int network_size, input int payload_width,
                                   input int seq_width);
      return payload_width + seq_width + node_width(network_size);
   endfunction

   // Type field LSB, directly below the packet MSB.
   function automatic int type_lsb(input int network_size, input int payload_width,
                                   input int seq_width);
      return payload_width + seq_width + 2 * node_width(network_size);
   endfunction

   // Packet layout at the default parameter set.
   typedef struct packed {
      logic [DEF_TYPE_WIDTH-1:0]    ptype;
      logic [DEF_NODE_WIDTH-1:0]    dest;
      logic [DEF_NODE_WIDTH-1:0]    source;
      logic [DEF_SEQ_WIDTH-1:0]     seq;
      logic [DEF_PAYLOAD_WIDTH-1:0] payload;
   } packet_t;

endpackage

// File: rtl/seq_reorder_buffer_dram.sv
// Simple dual-port distributed RAM holding the per-slot packet storage.
// Latency: write lands at the clock edge; read is combinational from the address.
// Backpressure: none, the caller qualifies writes with wr_en.
module distributedRAM_simpleDualPort #(
   parameter int DRAM_DEPTH = 256,
   parameter int DRAM_WIDTH = 44,
   parameter int ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DRAM_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DRAM_WIDTH-1:0] rd_data
);

   logic [DRAM_WIDTH-1:0] mem [DRAM_DEPTH];

   // Storage is deliberately not reset: slot counters decide which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Asynchronous read port feeds the release head directly.
   always_comb begin
      rd_data = mem[rd_addr];
   end

endmodule

// File: rtl/seq_reorder_buffer.sv
// Bins spike packets by sequence number into per-epoch slots and releases them strictly in epoch order.
// Latency: a packet written at the head of the current epoch appears on out_packet the next cycle.
// Backpressure: out_ready low holds out_packet; in_ready drops for a full slot or a write into a closing epoch.
module seq_reorder_buffer
   import snc_pkg::*;
#(
   parameter int NETWORK_SIZE   = 256,
   parameter int PAYLOAD_WIDTH  = 22,
   parameter int SEQ_WIDTH      = 4,
   parameter int TYPE_WIDTH     = 2,
   parameter int SLOT_DEPTH     = 16,
   parameter int EXPECT_DEFAULT = 16,
   parameter int TIMEOUT        = 1024,
   parameter int PACKET_SIZE    = packet_size(NETWORK_SIZE, PAYLOAD_WIDTH, SEQ_WIDTH, TYPE_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [PACKET_SIZE-1:0] in_packet,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [PACKET_SIZE-1:0] out_packet,
   input  logic                   out_ready,
   output logic [SEQ_WIDTH-1:0]   cur_seq,
   output logic                   epoch_done,
   output logic                   timeout_hit
);

   localparam int NUM_SLOTS  = 1 << SEQ_WIDTH;
   localparam int CNT_WIDTH  = $clog2(SLOT_DEPTH) + 1;
   localparam int IDX_WIDTH  = CNT_WIDTH - 1;
   localparam int ADDR_WIDTH = SEQ_WIDTH + IDX_WIDTH;
   localparam int SEQ_LSB    = seq_lsb(PAYLOAD_WIDTH);
   localparam int TYPE_LSB   = type_lsb(NETWORK_SIZE, PAYLOAD_WIDTH, SEQ_WIDTH);
   localparam int IDLE_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT    = CNT_WIDTH'(SLOT_DEPTH);
   localparam logic [CNT_WIDTH-1:0]  EXPECT_RESET = CNT_WIDTH'(EXPECT_DEFAULT);
   localparam logic [IDLE_WIDTH-1:0] IDLE_LAST    = IDLE_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TYPE_WIDTH-1:0] TYPE_CONF    = TYPE_WIDTH'(CONF_INPUTNUM);

   // Per-slot fill counters and release state.
   logic [CNT_WIDTH-1:0]  wr_cnt [NUM_SLOTS];
   logic [CNT_WIDTH-1:0]  rd_idx;
   logic [CNT_WIDTH-1:0]  expected;
   logic [IDLE_WIDTH-1:0] idle_cnt;

   // Write side decode.
   logic [SEQ_WIDTH-1:0]   in_seq;
   logic [CNT_WIDTH-1:0]   in_slot_cnt;
   logic                   in_to_cur;
   logic                   wr_en;
   logic [ADDR_WIDTH-1:0]  wr_addr;

   // Read side decode.
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [PACKET_SIZE-1:0] head_packet;
   logic [TYPE_WIDTH-1:0]  head_type;
   logic [CNT_WIDTH-1:0]   cur_slot_cnt;
   logic                   head_present;
   logic                   head_conf;
   logic                   head_data;
   logic                   data_fire;
   logic                   last_of_epoch;
   logic                   idle;
   logic                   close_data;
   logic                   close_conf;
   logic                   close_timeout;
   logic                   close_now;
   logic [CNT_WIDTH-1:0]   conf_raw;
   logic [CNT_WIDTH-1:0]   conf_expected;

   distributedRAM_simpleDualPort #(
      .DRAM_DEPTH (NUM_SLOTS * SLOT_DEPTH),
      .DRAM_WIDTH (PACKET_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (in_packet),
      .rd_addr (rd_addr),
      .rd_data (head_packet)
   );

   // Head decode: what sits at {cur_seq, rd_idx} and whether this cycle closes the epoch.
   always_comb begin
      rd_addr       = {cur_seq, rd_idx[IDX_WIDTH-1:0]};
      cur_slot_cnt  = wr_cnt[cur_seq];
      head_type     = head_packet[TYPE_LSB +: TYPE_WIDTH];
      head_present  = rd_idx < cur_slot_cnt;
      head_conf     = head_present && (head_type == TYPE_CONF);
      head_data     = head_present && (head_type != TYPE_CONF);
      data_fire     = head_data && out_ready;
      last_of_epoch = (rd_idx + CNT_WIDTH'(1)) >= expected;
      // An epoch that has released nothing yet is never force-closed.
      idle          = !head_present && (rd_idx != '0);
      close_data    = data_fire && last_of_epoch;
      close_conf    = head_conf;
      close_timeout = (TIMEOUT != 0) && idle && (idle_cnt == IDLE_LAST);
      close_now     = close_data || close_conf || close_timeout;
   end

   // Config payload becomes the next packet count; 0 or anything above the slot depth means a full slot.
   always_comb begin
      conf_raw      = head_packet[CNT_WIDTH-1:0];
      conf_expected = conf_raw;
      if ((conf_raw == '0) || (conf_raw > DEPTH_CNT)) begin
         conf_expected = DEPTH_CNT;
      end
   end

   // Write acceptance: refuse full slots and writes into the epoch closing this cycle.
   always_comb begin
      in_seq      = in_packet[SEQ_LSB +: SEQ_WIDTH];
      in_slot_cnt = wr_cnt[in_seq];
      in_to_cur   = in_seq == cur_seq;
      in_ready    = rst && (in_slot_cnt != DEPTH_CNT) && !(in_to_cur && close_now);
      wr_en       = in_valid && in_ready;
      wr_addr     = {in_seq, in_slot_cnt[IDX_WIDTH-1:0]};
   end

   // Output presentation; out_packet is forced to zero whenever nothing is offered.
   always_comb begin
      out_valid   = head_data;
      out_packet  = head_data ? head_packet : '0;
      epoch_done  = close_now;
      timeout_hit = close_timeout;
   end

   // Slot fill counters: the closing slot empties while other slots may still take a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            wr_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (close_now && (SEQ_WIDTH'(i) == cur_seq)) begin
               wr_cnt[i] <= '0;
            end else if (wr_en && (SEQ_WIDTH'(i) == in_seq)) begin
               wr_cnt[i] <= wr_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Release pointer and epoch advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_idx  <= '0;
         cur_seq <= '0;
      end else if (close_now) begin
         rd_idx  <= '0;
         cur_seq <= cur_seq + SEQ_WIDTH'(1);
      end else if (data_fire) begin
         rd_idx  <= rd_idx + CNT_WIDTH'(1);
      end
   end

   // Packet count per epoch; a config updates it for the epochs that follow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         expected <= EXPECT_RESET;
      end else if (close_conf) begin
         expected <= conf_expected;
      end
   end

   // Idle timer for a partially released epoch waiting on packets that may never come.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if (close_now || (wr_en && in_to_cur)) begin
         idle_cnt <= '0;
      end else if (idle && (TIMEOUT != 0)) begin
         idle_cnt <= idle_cnt + IDLE_WIDTH'(1);
      end
   end

endmodule

// File: doc/seq_reorder_buffer.md
# seq_reorder_buffer

Second-generation sequence-number reorder buffer for the PE receive path, sitting between the network interface and the multiply stage. Arriving spike packets are binned by sequence number into per-epoch slots of on-chip distributed RAM and released strictly in epoch order. Release of each epoch ends after a programmable packet count or on a configuration packet. Over the first generation it adds parametrised slot depth, output backpressure, internal consumption of config packets, full-slot flow control and an epoch timeout.

## Interface
Parameters:
- NETWORK_SIZE, 256, node count; SOURCE_WIDTH = DEST_WIDTH = $clog2(NETWORK_SIZE)
- PAYLOAD_WIDTH, 22, payload field width
- SEQ_WIDTH, 4, sequence field width; NUM_SLOTS = 2^SEQ_WIDTH
- TYPE_WIDTH, 2, packet type field width
- SLOT_DEPTH, 16, entries per slot (power of 2); CNT_WIDTH = $clog2(SLOT_DEPTH)+1
- EXPECT_DEFAULT, 16, packets per epoch after reset (1..SLOT_DEPTH)
- TIMEOUT, 1024, idle cycles before a partial epoch is force-closed; 0 disables
- PACKET_SIZE, derived: {type, dest, source, seq, payload}, MSB to LSB

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input packet valid
- in_packet  in  PACKET_SIZE  input packet
- in_ready  out  1  input accept
- out_valid  out  1  output packet valid
- out_packet  out  PACKET_SIZE  output packet; all zeros when out_valid = 0
- out_ready  in  1  downstream accept
- cur_seq  out  SEQ_WIDTH  epoch currently being released
- epoch_done  out  1  one-cycle pulse when an epoch closes
- timeout_hit  out  1  one-cycle pulse when the close was caused by timeout

## Operation
- State:
  - wr_cnt[NUM_SLOTS], CNT_WIDTH each
  - rd_idx, CNT_WIDTH
  - cur_seq
  - expected, CNT_WIDTH
  - idle_cnt
- Write: s = in_packet seq field. On in_valid & in_ready, the packet is stored at address {s, wr_cnt[s][CNT_WIDTH-2:0]} and wr_cnt[s] increments.
- in_ready = 0 when any of the following holds:
  - rst is asserted
  - wr_cnt[s] == SLOT_DEPTH (slot full)
  - s == cur_seq and close_now
- in_ready may depend combinationally on in_packet and out_ready.
- Head = entry {cur_seq, rd_idx}; head present when rd_idx < wr_cnt[cur_seq].
- Data head (type != CONF_INPUTNUM):
  - out_valid = 1.
  - On out_ready, rd_idx increments.
  - close_now = 1 if rd_idx+1 >= expected.
- Config head (type == CONF_INPUTNUM):
  - Consumed internally in one cycle; out_valid stays 0.
  - expected = payload[CNT_WIDTH-1:0], saturated to SLOT_DEPTH. A value of 0 is treated as SLOT_DEPTH.
  - close_now = 1.
- Timeout:
  - idle_cnt counts cycles in which the head is absent and rd_idx > 0.
  - idle_cnt clears on any write to cur_seq and on every close.
  - When TIMEOUT != 0 and idle_cnt == TIMEOUT-1, close_now = 1 and timeout_hit = 1.
- Close (close_now):
  - wr_cnt[cur_seq] is set to 0, rd_idx to 0, and cur_seq advances by 1 modulo NUM_SLOTS.
  - epoch_done pulses.
  - expected is kept; an updated value applies to the next epoch.
- Writes to other slots proceed in the same cycle as a close.
- An empty slot (rd_idx = 0, no head) never times out; release waits.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, out_packet = 0
  - cur_seq = 0, epoch_done = 0, timeout_hit = 0
  - all counters 0; expected = EXPECT_DEFAULT
- Reset is effective immediately on assertion. Deassertion is synchronised externally.
- Reset mid-epoch discards all stored packets.
- RAM write is synchronous; RAM read is combinational.
  - A packet accepted at edge N into slot cur_seq at the head position appears on out_valid/out_packet after edge N, in cycle N+1.
  - Sustained throughput: 1 packet/cycle in and 1 packet/cycle out.
- A config head costs one cycle with no output.
- The epoch close takes effect at the same edge as the last transfer. The new cur_seq's head can be valid in the next cycle.
- out_packet is stable while out_valid = 1 and out_ready = 0.
- Counters wrap only via close; wr_cnt never exceeds SLOT_DEPTH.

## Structure
- Package snc_pkg holds:
  - CONF_INPUTNUM = 2'b01 and DATA = 2'b00 type codes
  - field offset/width functions of the parameters
  - a packet struct
- One sub-module: distributedRAM_simpleDualPort with DRAM_DEPTH = NUM_SLOTS*SLOT_DEPTH and DRAM_WIDTH = PACKET_SIZE. It has one synchronous write port and one asynchronous read port.
- Counters, close logic and timeout live in the top module.

## Test plan
- In-order release: write seq 1 ×16, then seq 0 ×16, with out_ready = 1.
  - No output until seq 0 arrives.
  - Output is the 16 seq-0 packets, then the 16 seq-1 packets.
  - epoch_done pulses twice; cur_seq ends at 2.
- Config: seq 0 stream of config (payload 5), then 8 data packets.
  - out_valid stays 0 for the config; expected = 5.
  - Seq 0 closes immediately.
  - Seq 1 closes after exactly 5 outputs; the remaining seq-1 packets are discarded with the slot.
- Full slot: 17 packets to seq 3 while cur_seq = 0.
  - in_ready drops on the 17th; wr_cnt[3] = 16.
  - Packets to other seqs are still accepted that cycle.
- Backpressure: out_ready toggled randomly.
  - out_packet holds while stalled.
  - No loss or duplication against a scoreboard ordered by (seq, arrival).
- Timeout: TIMEOUT = 8; 3 packets to seq 0, with expected 16.
  - After the 3 outputs and 8 idle cycles, epoch_done and timeout_hit pulse together; cur_seq = 1.
  - Empty seq 1 then waits indefinitely.
- Reset mid-epoch: assert rst after 5 of 16 outputs.
  - Outputs go to zero immediately.
  - After release: cur_seq = 0, expected = EXPECT_DEFAULT, and no stale packets appear.
